// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF_ID/ID_RR/RR_EXE/EXE_WB pipeline latches.
// Also owns the fetch redirect handshake and keeps a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned ADDR_W            = 40,
  parameter int unsigned XCPT_DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W             = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DCACHE_BUSY,
  input  logic              MULDIV_BUSY,
  input  logic              LOAD_USE_HAZARD,
  input  logic              EXE_BRANCH_MISS,
  input  logic [ADDR_W-1:0] EXE_BRANCH_PC,
  input  logic              COMMIT_XCPT,
  input  logic [ADDR_W-1:0] XCPT_VECTOR,
  input  logic              FETCH_READY,
  output logic [3:0]        LOCK,
  output logic [3:0]        FLUSH_P1,
  output logic [3:0]        FLUSH_P2,
  output logic              REDIRECT_VALID,
  output logic [ADDR_W-1:0] REDIRECT_PC,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [1:0]        CTRL_STATE
);

  localparam int unsigned        DRAIN_W   = $clog2(XCPT_DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(XCPT_DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_REDIR = 2'd1,
    S_XCPT  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DRAIN_W-1:0]  r_drain_cnt, w_drain_nxt, w_drain_inc;
  logic [ADDR_W-1:0]   r_vector, w_vector_nxt;
  logic                r_redir_valid, w_redir_valid_nxt;
  logic [ADDR_W-1:0]   r_redir_pc, w_redir_pc_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [3:0]          w_lock, w_flush_p1, w_flush_p2;
  logic                w_busy;

  assign w_busy      = DCACHE_BUSY | MULDIV_BUSY;
  // Drain count as it will be after this cycle, saturating at the minimum drain time
  assign w_drain_inc = (r_drain_cnt == DRAIN_MAX) ? r_drain_cnt : r_drain_cnt + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_RUN;
      r_drain_cnt   <= '0;
      r_vector      <= '0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain_cnt   <= w_drain_nxt;
      r_vector      <= w_vector_nxt;
      r_redir_valid <= w_redir_valid_nxt;
      r_redir_pc    <= w_redir_pc_nxt;
      if ((|w_lock) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_drain_nxt       = r_drain_cnt;
    w_vector_nxt      = r_vector;
    w_redir_valid_nxt = r_redir_valid;
    w_redir_pc_nxt    = r_redir_pc;
    w_lock            = 4'b0000;
    w_flush_p1        = 4'b0000;
    w_flush_p2        = 4'b0000;
    case (r_state)
      S_RUN: begin
        if (COMMIT_XCPT) begin
          w_flush_p1   = 4'b1111;
          w_vector_nxt = XCPT_VECTOR;
          w_drain_nxt  = '0;
          w_state_nxt  = S_XCPT;
        end else if (EXE_BRANCH_MISS) begin
          w_flush_p1        = 4'b0111;
          w_redir_pc_nxt    = EXE_BRANCH_PC;
          w_redir_valid_nxt = 1'b1;
          w_state_nxt       = S_REDIR;
        end else if (w_busy) begin
          w_lock     = 4'b0111;
          w_flush_p2 = 4'b1000;
        end else if (LOAD_USE_HAZARD) begin
          w_lock     = 4'b0011;
          w_flush_p2 = 4'b0100;
        end
      end
      S_REDIR: begin
        // Keep wrong-path fetches out of ID until fetch takes the redirect
        w_flush_p2 = 4'b0001;
        if (COMMIT_XCPT) begin
          w_flush_p1        = 4'b1111;
          w_redir_valid_nxt = 1'b0;
          w_vector_nxt      = XCPT_VECTOR;
          w_drain_nxt       = '0;
          w_state_nxt       = S_XCPT;
        end else if (EXE_BRANCH_MISS) begin
          w_flush_p1     = 4'b0111;
          w_redir_pc_nxt = EXE_BRANCH_PC;
        end else begin
          if (w_busy) begin
            w_lock     = 4'b0110;
            w_flush_p2 = 4'b1001;
          end
          if (FETCH_READY) begin
            w_redir_valid_nxt = 1'b0;
            w_state_nxt       = S_RUN;
          end
        end
      end
      S_XCPT: begin
        w_flush_p1 = 4'b1111;
        if (COMMIT_XCPT) begin
          w_vector_nxt = XCPT_VECTOR;
          w_drain_nxt  = '0;
        end else begin
          w_drain_nxt = w_drain_inc;
          if ((w_drain_inc == DRAIN_MAX) && !DCACHE_BUSY) begin
            w_redir_pc_nxt    = r_vector;
            w_redir_valid_nxt = 1'b1;
            w_state_nxt       = S_REDIR;
          end
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign LOCK           = w_lock;
  assign FLUSH_P1       = w_flush_p1;
  assign FLUSH_P2       = w_flush_p2;
  assign REDIRECT_VALID = r_redir_valid;
  assign REDIRECT_PC    = r_redir_pc;
  assign STALL_CNT      = r_stall_cnt;
  assign CTRL_STATE     = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stall, branch redirect, exception drain and reset cases.
// Stall counter is narrowed so saturation can be reached quickly.
module tb_pipe_hazard_ctrl;

  localparam int unsigned ADDR_W = 40;
  localparam int unsigned DRAIN  = 4;
  localparam int unsigned CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              DCACHE_BUSY, MULDIV_BUSY, LOAD_USE_HAZARD;
  logic              EXE_BRANCH_MISS, COMMIT_XCPT, FETCH_READY;
  logic [ADDR_W-1:0] EXE_BRANCH_PC, XCPT_VECTOR;
  logic [3:0]        LOCK, FLUSH_P1, FLUSH_P2;
  logic              REDIRECT_VALID;
  logic [ADDR_W-1:0] REDIRECT_PC;
  logic [CNT_W-1:0]  STALL_CNT;
  logic [1:0]        CTRL_STATE;

  int n_err = 0;
  int n_chk = 0;

  pipe_hazard_ctrl #(
    .ADDR_W(ADDR_W), .XCPT_DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .DCACHE_BUSY(DCACHE_BUSY), .MULDIV_BUSY(MULDIV_BUSY), .LOAD_USE_HAZARD(LOAD_USE_HAZARD),
    .EXE_BRANCH_MISS(EXE_BRANCH_MISS), .EXE_BRANCH_PC(EXE_BRANCH_PC),
    .COMMIT_XCPT(COMMIT_XCPT), .XCPT_VECTOR(XCPT_VECTOR), .FETCH_READY(FETCH_READY),
    .LOCK(LOCK), .FLUSH_P1(FLUSH_P1), .FLUSH_P2(FLUSH_P2),
    .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .STALL_CNT(STALL_CNT), .CTRL_STATE(CTRL_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    DCACHE_BUSY = 0; MULDIV_BUSY = 0; LOAD_USE_HAZARD = 0;
    EXE_BRANCH_MISS = 0; COMMIT_XCPT = 0; FETCH_READY = 0;
    EXE_BRANCH_PC = '0; XCPT_VECTOR = '0;
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
  endtask

  initial begin
    // ---- reset state and load-use stall ----
    do_reset();
    chk("rst_state", 64'(CTRL_STATE), 64'd0);
    chk("rst_rv", 64'(REDIRECT_VALID), 64'd0);
    chk("rst_pc", 64'(REDIRECT_PC), 64'd0);
    chk("rst_stall", 64'(STALL_CNT), 64'd0);
    chk("rst_lock", 64'(LOCK), 64'd0);
    chk("rst_fp1", 64'(FLUSH_P1), 64'd0);
    chk("rst_fp2", 64'(FLUSH_P2), 64'd0);
    LOAD_USE_HAZARD = 1; #1;
    chk("lu0_lock", 64'(LOCK), 64'h3);
    chk("lu0_fp2", 64'(FLUSH_P2), 64'h4);
    chk("lu0_stall", 64'(STALL_CNT), 64'd0);
    cyc();
    chk("lu1_lock", 64'(LOCK), 64'h3);
    chk("lu1_fp2", 64'(FLUSH_P2), 64'h4);
    chk("lu1_stall", 64'(STALL_CNT), 64'd1);
    cyc(); LOAD_USE_HAZARD = 0; #1;
    chk("lu2_lock", 64'(LOCK), 64'h0);
    chk("lu2_stall", 64'(STALL_CNT), 64'd2);

    // ---- branch mispredict redirect ----
    do_reset();
    EXE_BRANCH_MISS = 1; EXE_BRANCH_PC = 40'h00_8000_0100; #1;
    chk("bm_fp1", 64'(FLUSH_P1), 64'h7);
    chk("bm_lock", 64'(LOCK), 64'h0);
    chk("bm_rv0", 64'(REDIRECT_VALID), 64'd0);
    cyc(); EXE_BRANCH_MISS = 0; #1;
    chk("bm1_rv", 64'(REDIRECT_VALID), 64'd1);
    chk("bm1_pc", 64'(REDIRECT_PC), 64'h80000100);
    chk("bm1_fp2", 64'(FLUSH_P2), 64'h1);
    chk("bm1_fp1", 64'(FLUSH_P1), 64'h0);
    chk("bm1_state", 64'(CTRL_STATE), 64'd1);
    cyc(); MULDIV_BUSY = 1; #1;
    chk("bm2_lock", 64'(LOCK), 64'h6);
    chk("bm2_fp2", 64'(FLUSH_P2), 64'h9);
    chk("bm2_rv", 64'(REDIRECT_VALID), 64'd1);
    cyc(); MULDIV_BUSY = 0; FETCH_READY = 1; #1;
    chk("bm3_rv", 64'(REDIRECT_VALID), 64'd1);
    chk("bm3_fp2", 64'(FLUSH_P2), 64'h1);
    cyc(); FETCH_READY = 0; #1;
    chk("bm4_rv", 64'(REDIRECT_VALID), 64'd0);
    chk("bm4_state", 64'(CTRL_STATE), 64'd0);
    chk("bm4_fp2", 64'(FLUSH_P2), 64'h0);
    chk("bm4_stall", 64'(STALL_CNT), 64'd1);
    // newer mispredict in the same cycle as FETCH_READY keeps the redirect alive
    EXE_BRANCH_MISS = 1; EXE_BRANCH_PC = 40'h1111; #1;
    cyc(); EXE_BRANCH_MISS = 0; #1;
    chk("bmf_pc0", 64'(REDIRECT_PC), 64'h1111);
    EXE_BRANCH_MISS = 1; EXE_BRANCH_PC = 40'h2222; FETCH_READY = 1; #1;
    chk("bmf_fp1", 64'(FLUSH_P1), 64'h7);
    cyc(); EXE_BRANCH_MISS = 0; FETCH_READY = 0; #1;
    chk("bmf_rv", 64'(REDIRECT_VALID), 64'd1);
    chk("bmf_pc", 64'(REDIRECT_PC), 64'h2222);
    chk("bmf_state", 64'(CTRL_STATE), 64'd1);

    // ---- exception with dcache busy until cycle 7 ----
    do_reset();
    COMMIT_XCPT = 1; XCPT_VECTOR = 40'h0000_0200; DCACHE_BUSY = 1; #1;
    chk("xb0_fp1", 64'(FLUSH_P1), 64'hF);
    chk("xb0_lock", 64'(LOCK), 64'h0);
    for (int c = 1; c <= 6; c++) begin
      cyc(); COMMIT_XCPT = 0; #1;
      chk("xb_fp1", 64'(FLUSH_P1), 64'hF);
      chk("xb_rv", 64'(REDIRECT_VALID), 64'd0);
    end
    cyc(); DCACHE_BUSY = 0; #1;
    chk("xb7_fp1", 64'(FLUSH_P1), 64'hF);
    chk("xb7_rv", 64'(REDIRECT_VALID), 64'd0);
    chk("xb7_state", 64'(CTRL_STATE), 64'd2);
    cyc(); #1;
    chk("xb8_rv", 64'(REDIRECT_VALID), 64'd1);
    chk("xb8_pc", 64'(REDIRECT_PC), 64'h200);
    chk("xb8_state", 64'(CTRL_STATE), 64'd1);

    // ---- exception with dcache idle: earliest redirect ----
    do_reset();
    COMMIT_XCPT = 1; XCPT_VECTOR = 40'h0000_0200; #1;
    for (int c = 1; c <= 4; c++) begin
      cyc(); COMMIT_XCPT = 0; #1;
      chk("xf_rv", 64'(REDIRECT_VALID), 64'd0);
    end
    cyc(); #1;
    chk("xf5_rv", 64'(REDIRECT_VALID), 64'd1);
    chk("xf5_pc", 64'(REDIRECT_PC), 64'h200);

    // ---- simultaneous exception, mispredict and busy ----
    do_reset();
    COMMIT_XCPT = 1; EXE_BRANCH_MISS = 1; MULDIV_BUSY = 1;
    XCPT_VECTOR = 40'h300; EXE_BRANCH_PC = 40'h999; #1;
    chk("pri_fp1", 64'(FLUSH_P1), 64'hF);
    chk("pri_lock", 64'(LOCK), 64'h0);
    chk("pri_fp2", 64'(FLUSH_P2), 64'h0);
    cyc(); clr_in(); #1;
    chk("pri_state", 64'(CTRL_STATE), 64'd2);
    chk("pri_rv", 64'(REDIRECT_VALID), 64'd0);
    chk("pri_stall", 64'(STALL_CNT), 64'd0);
    for (int c = 2; c <= 5; c++) cyc();
    chk("pri_pc", 64'(REDIRECT_PC), 64'h300);
    chk("pri_rv5", 64'(REDIRECT_VALID), 64'd1);

    // ---- exception preempts a pending redirect ----
    do_reset();
    EXE_BRANCH_MISS = 1; EXE_BRANCH_PC = 40'h1000; #1;
    cyc(); EXE_BRANCH_MISS = 0; COMMIT_XCPT = 1; XCPT_VECTOR = 40'h400; #1;
    chk("pre_fp1", 64'(FLUSH_P1), 64'hF);
    chk("pre_rv1", 64'(REDIRECT_VALID), 64'd1);
    chk("pre_lock", 64'(LOCK), 64'h0);
    cyc(); COMMIT_XCPT = 0; #1;
    chk("pre_rv2", 64'(REDIRECT_VALID), 64'd0);
    chk("pre_state", 64'(CTRL_STATE), 64'd2);
    for (int c = 3; c <= 6; c++) cyc();
    chk("pre_rv6", 64'(REDIRECT_VALID), 64'd1);
    chk("pre_pc", 64'(REDIRECT_PC), 64'h400);

    // ---- asynchronous reset in the middle of XCPT ----
    do_reset();
    MULDIV_BUSY = 1; #1;
    cyc(); cyc(); cyc();
    MULDIV_BUSY = 0; EXE_BRANCH_MISS = 1; EXE_BRANCH_PC = 40'h5555; #1;
    cyc(); EXE_BRANCH_MISS = 0; COMMIT_XCPT = 1; XCPT_VECTOR = 40'h600; #1;
    cyc(); COMMIT_XCPT = 0; #1;
    chk("ar_state0", 64'(CTRL_STATE), 64'd2);
    chk("ar_stall0", 64'(STALL_CNT), 64'd3);
    chk("ar_pc0", 64'(REDIRECT_PC), 64'h5555);
    #2 RST = 1'b1; #1;
    chk("ar_state", 64'(CTRL_STATE), 64'd0);
    chk("ar_fp1", 64'(FLUSH_P1), 64'h0);
    chk("ar_rv", 64'(REDIRECT_VALID), 64'd0);
    chk("ar_pc", 64'(REDIRECT_PC), 64'h0);
    chk("ar_stall", 64'(STALL_CNT), 64'd0);
    chk("ar_lock", 64'(LOCK), 64'h0);
    cyc(); RST = 1'b0;

    // ---- stall counter saturation ----
    do_reset();
    MULDIV_BUSY = 1; #1;
    for (int c = 1; c <= 15; c++) cyc();
    chk("sat_lock", 64'(LOCK), 64'h7);
    chk("sat15", 64'(STALL_CNT), 64'hF);
    cyc();
    chk("sat16", 64'(STALL_CNT), 64'hF);
    cyc();
    chk("sat17", 64'(STALL_CNT), 64'hF);
    MULDIV_BUSY = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
